// File: rtl/rdma_rsp_tid_tagger_pkg.sv
// Shared types for the RDMA read-response tid tagger: outstanding-request tag
// layout and the beat-size constant used to turn byte lengths into beats.
package rdma_rsp_tid_tagger_pkg;

  localparam int DATA_BITS_DEF = 512;
  localparam int VFID_BITS_DEF = 4;
  localparam int LEN_BITS_DEF  = 28;
  localparam int DEPTH_DEF     = 16;
  localparam int BYTES_LOG2    = $clog2(DATA_BITS_DEF / 8);

  typedef struct packed {
    logic [VFID_BITS_DEF-1:0] vfid;
    logic [LEN_BITS_DEF-1:0]  beats;
  } rd_tag_t;

  // Round a byte length up to whole beats; the sum wraps within LEN_BITS.
  function automatic logic [LEN_BITS_DEF-1:0] len_to_beats(input logic [LEN_BITS_DEF-1:0] len);
    return (len + LEN_BITS_DEF'((1 << BYTES_LOG2) - 1)) >> BYTES_LOG2;
  endfunction

endpackage

// File: rtl/rdma_tid_fifo.sv
// Register-based synchronous FIFO holding outstanding read tags; head is read
// combinationally so the data path sees the current tag with no extra cycle.
module rdma_tid_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: empty/full come from count alone.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rdma_rsp_tid_tagger.sv
// Tags RDMA read-response data with the vfid of the oldest outstanding request
// (tid) and checks each response's beat count against the request length.
module rdma_rsp_tid_tagger
  import rdma_rsp_tid_tagger_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int VFID_BITS = VFID_BITS_DEF,
  parameter int LEN_BITS  = LEN_BITS_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                     aclk,
  input  logic                     areset,

  input  logic                     s_req_valid,
  output logic                     s_req_ready,
  input  logic [VFID_BITS-1:0]     s_req_vfid,
  input  logic [LEN_BITS-1:0]      s_req_len,

  output logic                     m_req_valid,
  input  logic                     m_req_ready,
  output logic [VFID_BITS-1:0]     m_req_vfid,
  output logic [LEN_BITS-1:0]      m_req_len,

  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [DATA_BITS-1:0]     s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]   s_axis_tkeep,
  input  logic                     s_axis_tlast,

  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_BITS-1:0]     m_axis_tdata,
  output logic [DATA_BITS/8-1:0]   m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [VFID_BITS-1:0]     m_axis_tid,
  output logic [VFID_BITS-1:0]     m_axis_tdest,

  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_len,
  output logic [VFID_BITS-1:0]     err_vfid
);

  rd_tag_t             push_tag, head_tag;
  logic                full, empty;
  logic                req_hs, push, dat_hs, pop, len_bad;
  logic [LEN_BITS-1:0] beat_cnt, cnt_nxt;

  // Request path: pure pass-through, throttled only by tag space.
  assign m_req_valid = s_req_valid & ~full;
  assign s_req_ready = m_req_ready & ~full;
  assign m_req_vfid  = s_req_vfid;
  assign m_req_len   = s_req_len;
  assign req_hs      = s_req_valid & m_req_ready & ~full;
  // Zero-length reads return no data, so they leave no tag behind.
  assign push        = req_hs & (s_req_len != '0);
  assign push_tag    = '{vfid: s_req_vfid, beats: len_to_beats(s_req_len)};

  rdma_tid_fifo #(
    .W     ($bits(rd_tag_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (push),
    .pop    (pop),
    .din    (push_tag),
    .dout   (head_tag),
    .full   (full),
    .empty  (empty),
    .count  (occupancy)
  );

  // Data path: no tag, no forwarding.
  assign m_axis_tvalid = s_axis_tvalid & ~empty;
  assign s_axis_tready = m_axis_tready & ~empty;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tid    = head_tag.vfid;
  assign m_axis_tdest  = '0;
  assign dat_hs        = s_axis_tvalid & m_axis_tready & ~empty;
  assign pop           = dat_hs & s_axis_tlast;

  // A packet is wrong if tlast lands anywhere but on the expected final beat.
  assign cnt_nxt = beat_cnt + 1'b1;
  assign len_bad = s_axis_tlast ? (cnt_nxt != head_tag.beats)
                                : (cnt_nxt == head_tag.beats);

  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_cnt <= '0;
      err_len  <= 1'b0;
      err_vfid <= '0;
    end else if (dat_hs) begin
      beat_cnt <= s_axis_tlast ? '0 : cnt_nxt;
      if (len_bad && !err_len) begin
        err_len  <= 1'b1;
        err_vfid <= head_tag.vfid;
      end
    end
  end

endmodule

// File: tb/tb_rdma_rsp_tid_tagger.sv
// Scoreboard bench for rdma_rsp_tid_tagger: drivers queue expected beats, a
// negedge monitor tracks tag occupancy and sticky error as plain counters.
module tb_rdma_rsp_tid_tagger;

  localparam int DATA_BITS = 512;
  localparam int BYTES     = DATA_BITS / 8;
  localparam int VFID_BITS = 4;
  localparam int LEN_BITS  = 28;
  localparam int DEPTH     = 16;

  logic                   aclk, areset;
  logic                   s_req_valid, s_req_ready, m_req_valid, m_req_ready;
  logic [VFID_BITS-1:0]   s_req_vfid, m_req_vfid;
  logic [LEN_BITS-1:0]    s_req_len, m_req_len;
  logic                   s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DATA_BITS-1:0]   s_axis_tdata, m_axis_tdata;
  logic [BYTES-1:0]       s_axis_tkeep, m_axis_tkeep;
  logic                   m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [VFID_BITS-1:0]   m_axis_tid, m_axis_tdest, err_vfid;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   err_len;

  rdma_rsp_tid_tagger #(
    .DATA_BITS(DATA_BITS), .VFID_BITS(VFID_BITS), .LEN_BITS(LEN_BITS), .DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_vfid(s_req_vfid), .s_req_len(s_req_len),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_vfid(m_req_vfid), .m_req_len(m_req_len),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
    .occupancy(occupancy), .err_len(err_len), .err_vfid(err_vfid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic [BYTES-1:0]     keep;
    logic                 last;
    logic [3:0]           tid;
    bit                   err_here;
  } beat_t;

  typedef struct {
    logic [3:0] vfid;
    int         beats;
  } tag_t;

  beat_t      expq[$];
  tag_t       pending[$];
  int         occ;
  bit         exp_err;
  logic [3:0] exp_errv;
  bit         bp_en = 0;

  // Ready backpressure for the random phase; both readies held high otherwise.
  always @(posedge aclk) begin
    #1;
    if (bp_en) begin
      m_axis_tready = ($urandom % 4) != 0;
      m_req_ready   = ($urandom % 4) != 0;
    end else begin
      m_axis_tready = 1'b1;
      m_req_ready   = 1'b1;
    end
  end

  // Monitor: per-cycle expectations from the outstanding-tag count and queues.
  always @(negedge aclk) begin
    bit hs, push_m, pop_m;
    if (areset) begin
      occ = 0;
      expq.delete();
      exp_err = 0;
      exp_errv = '0;
    end else begin
      chk("m_req_valid", m_req_valid, s_req_valid && occ < DEPTH);
      chk("s_req_ready", s_req_ready, m_req_ready && occ < DEPTH);
      if (m_req_valid) begin
        chk("m_req_vfid", m_req_vfid, s_req_vfid);
        chk("m_req_len", m_req_len, s_req_len);
      end
      chk("m_axis_tvalid", m_axis_tvalid, s_axis_tvalid && occ > 0);
      chk("s_axis_tready", s_axis_tready, m_axis_tready && occ > 0);
      chk("occupancy", occupancy, occ);
      chk("tdest", m_axis_tdest, 0);
      chk("err_len", err_len, exp_err);
      chk("err_vfid", err_vfid, exp_errv);
      hs = s_axis_tvalid && m_axis_tready && occ > 0;
      if (hs) begin
        if (expq.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          beat_t e;
          e = expq.pop_front();
          chk("tdata", m_axis_tdata, e.data);
          chk("tkeep", m_axis_tkeep, e.keep);
          chk("tlast", m_axis_tlast, e.last);
          chk("tid", m_axis_tid, e.tid);
          if (e.err_here && !exp_err) begin
            exp_err = 1;
            exp_errv = e.tid;
          end
        end
      end
      push_m = s_req_valid && m_req_ready && occ < DEPTH && s_req_len != 0;
      pop_m  = hs && s_axis_tlast;
      occ = occ + int'(push_m) - int'(pop_m);
    end
  end

  // All driver tasks are entered and left at posedge+1.
  task automatic send_req(input logic [3:0] v, input logic [27:0] l);
    int t = 0;
    s_req_valid = 1; s_req_vfid = v; s_req_len = l;
    forever begin
      @(negedge aclk);
      if (s_req_ready) break;
      t++;
      if (t > 300) begin chk("req_timeout", 1, 0); break; end
    end
    if (s_req_ready && l != 0) pending.push_back('{v, (int'(l) + BYTES - 1) / BYTES});
    @(posedge aclk); #1;
    s_req_valid = 0;
  endtask

  task automatic send_beats(input logic [3:0] tid, input int n, input bit last_final, input int err_idx);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      int t;
      for (int w = 0; w < DATA_BITS / 32; w++) b.data[w*32 +: 32] = $urandom;
      b.keep = {$urandom, $urandom};
      b.last = last_final && (i == n - 1);
      b.tid = tid;
      b.err_here = (i == err_idx);
      s_axis_tdata = b.data; s_axis_tkeep = b.keep; s_axis_tlast = b.last;
      s_axis_tvalid = 1;
      expq.push_back(b);
      t = 0;
      forever begin
        @(negedge aclk);
        if (s_axis_tready) break;
        t++;
        if (t > 300) begin chk("beat_timeout", 1, 0); break; end
      end
      @(posedge aclk); #1;
    end
    s_axis_tvalid = 0; s_axis_tlast = 0;
  endtask

  // Sends the packet for the oldest accepted request, delta beats off length.
  task automatic send_pkt_next(input int delta);
    tag_t tg;
    int t = 0, n, e;
    while (pending.size() == 0) begin
      @(negedge aclk);
      t++;
      if (t > 300) begin chk("pkt_timeout", 1, 0); return; end
    end
    if (t > 0) begin @(posedge aclk); #1; end
    tg = pending.pop_front();
    n = tg.beats + delta;
    if (n < 1) n = 1;
    e = (n == tg.beats) ? -1 : (((n < tg.beats) ? n : tg.beats) - 1);
    send_beats(tg.vfid, n, 1, e);
  endtask

  initial begin
    #500000;
    chk("watchdog", 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    areset = 1; s_req_valid = 0; s_req_vfid = 0; s_req_len = 0;
    s_axis_tvalid = 1; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0;
    m_req_ready = 1; m_axis_tready = 1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_req_valid", m_req_valid, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_err_vfid", err_vfid, 0);
    @(posedge aclk); #1;
    areset = 0; s_axis_tvalid = 0;

    // single 2-beat packet
    send_req(4'd3, 28'd128);
    @(negedge aclk); chk("t1_occ1", occupancy, 1);
    @(posedge aclk); #1;
    send_pkt_next(0);
    @(negedge aclk); chk("t1_occ0", occupancy, 0); chk("t1_err", err_len, 0);
    @(posedge aclk); #1;

    // three outstanding requests
    send_req(4'd1, 28'd64); send_req(4'd2, 28'd192); send_req(4'd5, 28'd1);
    repeat (3) send_pkt_next(0);
    @(negedge aclk); chk("t2_occ0", occupancy, 0);
    @(posedge aclk); #1;

    // fill, block, then one pop re-opens the request path
    for (int i = 0; i < DEPTH; i++) send_req(4'(i), 28'd64);
    fork
      send_req(4'd15, 28'd64);
      begin
        repeat (3) @(negedge aclk);
        chk("t3_blocked", s_req_ready, 0);
        chk("t3_full", occupancy, DEPTH);
        @(posedge aclk); #1;
        send_pkt_next(0);
      end
    join
    repeat (DEPTH) send_pkt_next(0);
    @(negedge aclk); chk("t3_drained", occupancy, 0);
    @(posedge aclk); #1;

    // data waiting before its request
    s_axis_tvalid = 1; s_axis_tlast = 1;
    repeat (3) begin @(negedge aclk); chk("t4_held", m_axis_tvalid, 0); end
    @(posedge aclk); #1;
    fork
      send_req(4'd7, 28'd64);
      send_pkt_next(0);
    join

    // short packet flags the error, next packet still tagged
    send_req(4'd4, 28'd256);
    send_pkt_next(-2);
    @(negedge aclk);
    chk("t5_err_len", err_len, 1); chk("t5_err_vfid", err_vfid, 4); chk("t5_popped", occupancy, 0);
    @(posedge aclk); #1;
    send_req(4'd6, 28'd64);
    send_pkt_next(0);
    @(negedge aclk); chk("t5_err_hold", err_vfid, 4);
    @(posedge aclk); #1;

    // randomized traffic with backpressure and occasional length errors
    bp_en = 1;
    for (int it = 0; it < 40; it++) begin
      int k, nz;
      logic [3:0]  vv[4];
      logic [27:0] ll[4];
      k = $urandom_range(1, 4);
      nz = 0;
      for (int j = 0; j < k; j++) begin
        vv[j] = 4'($urandom);
        ll[j] = (($urandom % 6) == 0) ? 28'd0 : 28'($urandom_range(1, 640));
        if (ll[j] != 0) nz++;
      end
      fork
        for (int j = 0; j < k; j++) send_req(vv[j], ll[j]);
        for (int j = 0; j < nz; j++) begin
          int r;
          r = $urandom % 6;
          send_pkt_next(r == 0 ? 1 : (r == 1 ? -1 : 0));
        end
      join
    end
    bp_en = 0;
    repeat (2) @(posedge aclk); #1;

    // reset in the middle of a packet
    send_req(4'd2, 28'd256);
    begin
      tag_t tg;
      tg = pending.pop_front();
      send_beats(tg.vfid, 2, 0, -1);
    end
    areset = 1;
    @(posedge aclk); #1;
    areset = 0; pending.delete();
    s_axis_tvalid = 1; s_axis_tlast = 0;
    @(negedge aclk);
    chk("t6_occ", occupancy, 0); chk("t6_tvalid", m_axis_tvalid, 0);
    chk("t6_err_len", err_len, 0); chk("t6_err_vfid", err_vfid, 0);
    @(posedge aclk); #1;
    s_axis_tvalid = 0;
    send_req(4'd9, 28'd64);
    send_pkt_next(0);
    @(negedge aclk); chk("t6_after", occupancy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
